// File: rtl/multi_tick_gen_pkg.sv
// Shared definitions for the multi-channel tick generator: mode encodings
// and default sizing.
package multi_tick_gen_pkg;

  localparam int unsigned NBIT_DEFAULT = 18;
  localparam int unsigned NCH_DEFAULT  = 4;

  // Per-channel operating mode; code 3 behaves as a second periodic-pulse code.
  typedef enum logic [1:0] {
    MODE_TOGGLE    = 2'd0,
    MODE_PULSE     = 2'd1,
    MODE_ONESHOT   = 2'd2,
    MODE_PULSE_ALT = 2'd3
  } tick_mode_e;

endpackage

// File: rtl/multi_tick_gen_tick_chan.sv
// One tick-generator channel: programmable-period counter producing a
// divided square wave, a wrap pulse and a sticky one-shot completion flag.
module tick_chan
  import multi_tick_gen_pkg::*;
#(
  parameter int unsigned NBIT = NBIT_DEFAULT
) (
  input  logic            clk_base,
  input  logic            reset,
  input  logic            en,
  input  logic            clr,
  input  logic [1:0]      mode,
  input  logic [NBIT-1:0] limit,
  output logic            clk_out,
  output logic            tick,
  output logic            busy,
  output logic            done
);

  tick_mode_e      mode_e;
  logic [NBIT-1:0] cnt;
  logic [NBIT-1:0] act_lim;
  logic            en_q;

  logic [NBIT-1:0] cnt_nxt;
  logic [NBIT-1:0] act_lim_nxt;
  logic [NBIT-1:0] lim_use;
  logic            clk_out_nxt;
  logic            tick_nxt;
  logic            done_nxt;
  logic            busy_nxt;
  logic            restart;
  logic            done_eff;
  logic            halted;

  assign mode_e = tick_mode_e'(mode);

  // Next-state decode: clear beats enable; a rising enable restarts the
  // channel on the same edge, clearing done and comparing against the live
  // limit so the first period after a restart already has length L+1.
  always_comb begin
    cnt_nxt     = cnt;
    act_lim_nxt = act_lim;
    clk_out_nxt = clk_out;
    tick_nxt    = 1'b0;
    done_nxt    = done;
    restart     = en & ~en_q;
    done_eff    = done & ~restart;
    halted      = (mode_e == MODE_ONESHOT) & done_eff;
    lim_use     = restart ? limit : act_lim;

    if (clr) begin
      cnt_nxt     = '0;
      act_lim_nxt = limit;
      clk_out_nxt = 1'b1;
      done_nxt    = 1'b0;
    end else if (!en) begin
      act_lim_nxt = limit;
    end else begin
      done_nxt = done_eff;
      if (restart) begin
        act_lim_nxt = limit;
      end
      if (!halted) begin
        if (cnt >= lim_use) begin
          cnt_nxt     = '0;
          tick_nxt    = 1'b1;
          act_lim_nxt = limit;
          if (mode_e == MODE_TOGGLE) begin
            clk_out_nxt = ~clk_out;
          end
          if (mode_e == MODE_ONESHOT) begin
            done_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + NBIT'(1);
        end
      end
    end

    busy_nxt = en & ~clr & ~((mode_e == MODE_ONESHOT) & done_nxt);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk_base or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      act_lim <= '0;
      en_q    <= 1'b0;
      clk_out <= 1'b1;
      tick    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      act_lim <= act_lim_nxt;
      en_q    <= en;
      clk_out <= clk_out_nxt;
      tick    <= tick_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

endmodule

// File: rtl/multi_tick_gen.sv
// Multi-channel tick generator: NCH independent tick_chan instances sharing
// one clock and reset; the top level only slices the packed buses.
module multi_tick_gen
  import multi_tick_gen_pkg::*;
#(
  parameter int unsigned NBIT = NBIT_DEFAULT,
  parameter int unsigned NCH  = NCH_DEFAULT
) (
  input  logic                clk_base,
  input  logic                reset,
  input  logic [NCH-1:0]      en,
  input  logic [NCH-1:0]      clr,
  input  logic [2*NCH-1:0]    mode,
  input  logic [NCH*NBIT-1:0] limit,
  output logic [NCH-1:0]      clk_out,
  output logic [NCH-1:0]      tick,
  output logic [NCH-1:0]      busy,
  output logic [NCH-1:0]      done
);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    tick_chan #(
      .NBIT (NBIT)
    ) u_chan (
      .clk_base (clk_base),
      .reset    (reset),
      .en       (en[i]),
      .clr      (clr[i]),
      .mode     (mode[2*i +: 2]),
      .limit    (limit[i*NBIT +: NBIT]),
      .clk_out  (clk_out[i]),
      .tick     (tick[i]),
      .busy     (busy[i]),
      .done     (done[i])
    );
  end

endmodule

// File: tb/tb_multi_tick_gen.sv
// Scoreboard bench for multi_tick_gen: a behavioural model predicts the
// outputs after every clock edge; a monitor compares them one cycle later.
module tb_multi_tick_gen;
  import multi_tick_gen_pkg::*;

  localparam int unsigned NBIT = 18;
  localparam int unsigned NCH  = 4;

  logic                clk_base = 1'b0;
  logic                reset;
  logic [NCH-1:0]      en;
  logic [NCH-1:0]      clr;
  logic [2*NCH-1:0]    mode;
  logic [NCH*NBIT-1:0] limit;
  logic [NCH-1:0]      clk_out;
  logic [NCH-1:0]      tick;
  logic [NCH-1:0]      busy;
  logic [NCH-1:0]      done;

  typedef struct packed {
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] done;
  } obs_t;

  obs_t exp_q[$];
  obs_t exp_o;
  obs_t act_o;
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model state: position in period, latched period length, flags.
  int unsigned    m_pos[NCH];
  int unsigned    m_per[NCH];
  logic [NCH-1:0] m_sq;
  logic [NCH-1:0] m_pulse;
  logic [NCH-1:0] m_run;
  logic [NCH-1:0] m_fin;
  logic [NCH-1:0] m_was_en;

  multi_tick_gen #(
    .NBIT (NBIT),
    .NCH  (NCH)
  ) dut (
    .clk_base (clk_base),
    .reset    (reset),
    .en       (en),
    .clr      (clr),
    .mode     (mode),
    .limit    (limit),
    .clk_out  (clk_out),
    .tick     (tick),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk_base = ~clk_base;

  task automatic chk(input string nm, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // Predict the effect of the coming edge from the current inputs.
  task automatic model_step(output obs_t o);
    for (int c = 0; c < int'(NCH); c++) begin
      int unsigned lv;
      int          md;
      lv = int'(limit[c*NBIT +: NBIT]);
      md = int'(mode[2*c +: 2]);
      if (!reset) begin
        m_pos[c] = 0; m_per[c] = 0; m_sq[c] = 1'b1; m_pulse[c] = 1'b0;
        m_run[c] = 1'b0; m_fin[c] = 1'b0; m_was_en[c] = 1'b0;
      end else begin
        m_pulse[c] = 1'b0;
        if (clr[c]) begin
          m_pos[c] = 0; m_per[c] = lv; m_sq[c] = 1'b1; m_fin[c] = 1'b0;
        end else if (!en[c]) begin
          m_per[c] = lv;
        end else begin
          if (!m_was_en[c]) begin
            m_fin[c] = 1'b0;
            m_per[c] = lv;
          end
          if (!(md == 2 && m_fin[c])) begin
            if (m_pos[c] < m_per[c]) begin
              m_pos[c] = m_pos[c] + 1;
            end else begin
              m_pos[c]   = 0;
              m_pulse[c] = 1'b1;
              m_per[c]   = lv;
              if (md == 0) m_sq[c] = ~m_sq[c];
              if (md == 2) m_fin[c] = 1'b1;
            end
          end
        end
        m_run[c]    = en[c] && !clr[c] && !(md == 2 && m_fin[c]);
        m_was_en[c] = en[c];
      end
    end
    o.clk_out = m_sq;
    o.tick    = m_pulse;
    o.busy    = m_run;
    o.done    = m_fin;
  endtask

  // Apply current inputs for one edge; outputs are sampled on the falling edge.
  task automatic step();
    obs_t o;
    model_step(o);
    exp_q.push_back(o);
    @(posedge clk_base);
    @(negedge clk_base);
    #1;
  endtask

  task automatic set_lim(input int c, input int unsigned v);
    limit[c*NBIT +: NBIT] = NBIT'(v);
  endtask

  task automatic set_mode(input int c, input int m);
    mode[2*c +: 2] = 2'(m);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    en    = '0;
    clr   = '0;
    for (int c = 0; c < int'(NCH); c++) begin
      set_mode(c, 1);
      set_lim(c, 0);
    end
    step();
    step();
    reset = 1'b1;
  endtask

  // Monitor: every registered output set is compared with its prediction.
  always @(negedge clk_base) begin
    if (exp_q.size() > 0) begin
      exp_o = exp_q.pop_front();
      act_o = {clk_out, tick, busy, done};
      n_vec++;
      if (act_o !== exp_o) begin
        n_bad++;
        $display("FAIL scoreboard t=%0t: got clk_out=%b tick=%b busy=%b done=%b, expected clk_out=%b tick=%b busy=%b done=%b",
                 $time, act_o.clk_out, act_o.tick, act_o.busy, act_o.done,
                 exp_o.clk_out, exp_o.tick, exp_o.busy, exp_o.done);
      end
    end
  end

  initial begin
    int first, cnt_t, cnt_h, bad_gap, last_chg, t1, t2, t3, d8, b8, snap, chg, all4;
    int tcnt[NCH];
    logic prev;

    reset = 1'b0; en = '0; clr = '0; mode = '0; limit = '0;

    // Reset with arbitrary inputs, then release with en=1 and L=3.
    for (int c = 0; c < int'(NCH); c++) begin
      set_lim(c, $urandom_range(0, 1000));
      set_mode(c, $urandom_range(0, 3));
    end
    for (int k = 0; k < 3; k++) begin
      en  = NCH'($urandom);
      clr = NCH'($urandom);
      step();
    end
    chk("rst_clk_out", int'(clk_out), (1 << NCH) - 1);
    chk("rst_tick", int'(tick), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    reset = 1'b1; clr = '0; en = '1;
    for (int c = 0; c < int'(NCH); c++) begin
      set_mode(c, 1);
      set_lim(c, 3);
    end
    first = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (tick[0] && first == 0) first = k;
    end
    chk("rst_first_tick_edge", first, 4);

    // Toggle mode, L=4, 40 enabled cycles.
    do_reset();
    set_mode(0, 0); set_lim(0, 4); en = 4'b0001;
    cnt_t = 0; cnt_h = 0; bad_gap = 0; last_chg = 0; chg = 0;
    prev = clk_out[0];
    for (int k = 1; k <= 40; k++) begin
      step();
      cnt_t += int'(tick[0]);
      cnt_h += int'(clk_out[0]);
      if (clk_out[0] != prev) begin
        chg++;
        if (k - last_chg != 5) bad_gap++;
        last_chg = k;
        prev = clk_out[0];
      end
    end
    chk("tog_ticks", cnt_t, 8);
    chk("tog_high_cycles", cnt_h, 20);
    chk("tog_edges", chg, 8);
    chk("tog_half_period_err", bad_gap, 0);

    // One-shot, L=7, then restart via en 0->1.
    do_reset();
    set_mode(0, 2); set_lim(0, 7); en = 4'b0001;
    first = 0; cnt_t = 0; d8 = 0; b8 = 1;
    for (int k = 1; k <= 28; k++) begin
      step();
      if (tick[0]) begin
        cnt_t++;
        if (first == 0) first = k;
      end
      if (k == 8) begin
        d8 = int'(done[0]);
        b8 = int'(busy[0]);
      end
    end
    chk("os_first_tick_edge", first, 8);
    chk("os_tick_count", cnt_t, 1);
    chk("os_done_at_8", d8, 1);
    chk("os_busy_at_8", b8, 0);
    en = '0; step();
    en = 4'b0001; first = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 1) chk("os_done_cleared", int'(done[0]), 0);
      if (tick[0] && first == 0) first = k;
    end
    chk("os_retrigger_edge", first, 8);

    // Limit change from 9 to 2 at cnt=5.
    do_reset();
    set_mode(0, 1); set_lim(0, 9); en = 4'b0001;
    repeat (5) step();
    set_lim(0, 2);
    t1 = 0; t2 = 0; t3 = 0;
    for (int k = 6; k <= 20; k++) begin
      step();
      if (tick[0]) begin
        if (t1 == 0) t1 = k;
        else if (t2 == 0) t2 = k;
        else if (t3 == 0) t3 = k;
      end
    end
    chk("lim_first_period", t1, 10);
    chk("lim_second_period", t2 - t1, 3);
    chk("lim_third_period", t3 - t2, 3);

    // Pause mid-period, resume, then clear while enabled.
    do_reset();
    set_mode(0, 0); set_lim(0, 4); en = 4'b0001;
    repeat (7) step();
    snap = int'(clk_out[0]);
    chk("pause_pre_clk_out", snap, 0);
    en = '0; cnt_t = 0; chg = 0;
    repeat (6) begin
      step();
      cnt_t += int'(tick[0]);
      if (int'(clk_out[0]) != snap) chg++;
    end
    chk("pause_ticks", cnt_t, 0);
    chk("pause_clk_out_moves", chg, 0);
    en = 4'b0001; first = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (tick[0]) begin first = k; break; end
    end
    chk("pause_resume_edge", first, 3);
    repeat (5) step();
    chk("clr_pre_clk_out", int'(clk_out[0]), 0);
    clr = 4'b0001;
    step();
    chk("clr_clk_out", int'(clk_out[0]), 1);
    chk("clr_tick", int'(tick[0]), 0);
    clr = '0; first = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (tick[0]) begin first = k; break; end
    end
    chk("clr_restart_edge", first, 5);

    // Channel independence, L={0,1,2,3}.
    do_reset();
    for (int c = 0; c < int'(NCH); c++) begin
      set_mode(c, 1);
      set_lim(c, c);
      tcnt[c] = 0;
    end
    en = '1; all4 = 0;
    for (int k = 1; k <= 24; k++) begin
      step();
      for (int c = 0; c < int'(NCH); c++) tcnt[c] += int'(tick[c]);
      if (tick == 4'b1111) all4++;
    end
    chk("ind_ch0_ticks", tcnt[0], 24);
    chk("ind_ch1_ticks", tcnt[1], 12);
    chk("ind_ch2_ticks", tcnt[2], 8);
    chk("ind_ch3_ticks", tcnt[3], 6);
    chk("ind_coincident", all4, 2);

    // Randomized traffic, including mid-period resets.
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      reset = ($urandom_range(0, 199) != 0);
      for (int c = 0; c < int'(NCH); c++) begin
        en[c]  = ($urandom_range(0, 7) != 0);
        clr[c] = ($urandom_range(0, 31) == 0);
        if ($urandom_range(0, 19) == 0) set_mode(c, $urandom_range(0, 3));
        if ($urandom_range(0, 9) == 0) set_lim(c, $urandom_range(0, 12));
      end
      step();
    end

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk_base);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_tick_gen.md
MULTI_TICK_GEN -- requirements
Module: multi_tick_gen

Interface
REQ-001 The module SHALL have parameter NBIT, default 18, giving the counter and limit width per channel.
REQ-002 The module SHALL have parameter NCH, default 4, giving the number of independent channels (1..16).
REQ-003 The module SHALL have port clk_base, in, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port reset, in, 1 bit: asynchronous, active-low reset; the block is in reset while reset is 0.
REQ-005 The module SHALL have port en, in, NCH bits: per-channel run enable; 0 pauses the channel.
REQ-006 The module SHALL have port clr, in, NCH bits: per-channel synchronous clear.
REQ-007 The module SHALL have port mode, in, 2*NCH bits: per-channel mode, channel i in bits [2i+1:2i]; 0 = toggle, 1 = periodic pulse, 2 = one-shot, 3 = periodic pulse.
REQ-008 The module SHALL have port limit, in, NCH*NBIT bits: per-channel terminal count L, channel i in bits [(i+1)*NBIT-1:i*NBIT].
REQ-009 The module SHALL have port clk_out, out, NCH bits: per-channel divided square wave.
REQ-010 The module SHALL have port tick, out, NCH bits: per-channel single-cycle pulse, asserted for one cycle at each wrap.
REQ-011 The module SHALL have port busy, out, NCH bits: the channel is counting.
REQ-012 The module SHALL have port done, out, NCH bits: sticky one-shot completion flag.

Function
REQ-013 Each channel SHALL hold an NBIT counter cnt and an NBIT active limit act_lim; all outputs SHALL be registered.
REQ-014 act_lim SHALL load from limit on every edge where en=0 or clr=1, and on every wrap edge; limit changes mid-period SHALL NOT affect the current period.
REQ-015 On an edge with en=1, clr=0 and the channel not halted: if cnt >= act_lim, cnt SHALL go to 0 (wrap) and tick SHALL be 1 for the next cycle; otherwise cnt SHALL increment and tick SHALL be 0.
REQ-016 Period SHALL be L+1 enabled cycles; L=0 SHALL give tick=1 on every enabled cycle.
REQ-017 In mode 0, clk_out SHALL invert at each wrap, giving a period of 2*(L+1) cycles; in modes 1-3, clk_out SHALL hold its value.
REQ-018 In mode 2, the first wrap SHALL set done=1 and halt the channel with cnt=0; a halted channel SHALL produce no further ticks.
REQ-019 done SHALL clear on clr=1 or on a 0->1 transition of en; this restart SHALL begin counting on the same edge.
REQ-020 busy SHALL equal the registered value of en & ~clr & ~(mode==2 & done).
REQ-021 With en=0, cnt, clk_out and done SHALL hold, and tick SHALL be 0.
REQ-022 clr SHALL take priority over en: cnt=0, clk_out=1, tick=0, done=0.
REQ-023 A mode change SHALL take effect on the next edge without clearing cnt.
REQ-024 Channels SHALL be fully independent; simultaneous wraps SHALL raise multiple tick bits in the same cycle.

Reset
REQ-025 While reset=0, every channel SHALL have cnt=0, act_lim=0, clk_out=1, tick=0, busy=0, done=0, and the en-edge detector SHALL read 0.
REQ-026 Reset assertion mid-period SHALL abort the period immediately; after release, counting SHALL resume from cnt=0 on the first edge with en=1.

Structure
REQ-027 Mode encodings MODE_TOGGLE, MODE_PULSE and MODE_ONESHOT SHALL reside in a shared package/header, together with the defaults for NBIT and NCH.
REQ-028 One channel SHALL be a sub-module tick_chan (parameter NBIT), instantiated NCH times by a generate loop; the top level SHALL only slice the buses.

Verification
REQ-029 Bench SHALL check reset: hold reset=0 with arbitrary inputs -> all outputs at reset values; release with en=1, L=3 -> first tick in the cycle after the 4th edge.
REQ-030 Bench SHALL check toggle mode: mode 0, L=4, en=1 for 40 cycles -> clk_out period of 10 cycles, 50% duty, tick every 5 cycles.
REQ-031 Bench SHALL check one-shot: mode 2, L=7 -> one tick, done=1 and busy=0 after 8 edges, with no tick over the next 20 cycles; toggling en 0->1 -> a new tick 8 edges later.
REQ-032 Bench SHALL check limit change: L changed from 9 to 2 at cnt=5 -> the current period ends at 10 cycles, subsequent periods are 3 cycles.
REQ-033 Bench SHALL check pause and clear: en=0 for 6 cycles mid-period -> cnt and clk_out frozen, tick=0; clr together with en=1 -> cnt=0 and clk_out=1 on the next cycle.
REQ-034 Bench SHALL check channel independence: NCH=4 with L={0,1,2,3} -> per-channel tick periods of 1, 2, 3 and 4 cycles, with coincident ticks every 12 cycles.
